// File: rtl/store_align_unit_pkg.sv
// Shared encodings for the store alignment unit.
// Latency: n/a (types only).
// Backpressure: n/a.
package store_align_unit_pkg;

  // Store size as presented on size_i.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Issue FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_e;

endpackage

// File: rtl/store_align_unit_lane_steer.sv
// Narrows a register value to the store size and shifts it onto byte lanes across two words.
// Latency: purely combinational.
// Backpressure: none.
// Ports: size/offset/data in; be_lo/be_hi (lanes of beat 0 / beat 1), 64-bit shifted data,
//        split (store touches the second word) and illegal (size encoding 11).
module store_lane_steer
  import store_align_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [63:0] wdata,
  output logic        split,
  output logic        illegal
);

  logic [3:0]  mask;
  logic [31:0] narrow;
  logic [7:0]  be8;

  always_comb begin
    mask    = 4'b0000;
    narrow  = 32'h0;
    illegal = 1'b0;
    case (size)
      SZ_BYTE: begin
        mask   = 4'b0001;
        narrow = {24'h0, data[7:0]};
      end
      SZ_HALF: begin
        mask   = 4'b0011;
        narrow = {16'h0, data[15:0]};
      end
      SZ_WORD: begin
        mask   = 4'b1111;
        narrow = data;
      end
      default: illegal = 1'b1;
    endcase

    // Shifting across an 8-lane window lets lanes past 3 fall naturally into the next word.
    be8   = {4'b0000, mask} << offset;
    wdata = {32'h0, narrow} << {offset, 3'b000};
    be_lo = be8[3:0];
    be_hi = be8[7:4];
    split = |be8[7:4];
  end

endmodule

// File: rtl/store_align_unit.sv
// Store aligner: narrows, lane-steers and issues a store to data memory, splitting misaligned ones in two beats.
// Latency: beat 0 valid the cycle after accept; done_o one cycle after the final beat handshake.
// Backpressure: beat outputs held stable until mem_ready_i; req_ready_o low while a store is in flight.
// Ports: clk_i, rst_i (async active-low); req_valid_i/req_ready_o with addr_i, data_i, size_i;
//        mem_valid_o/mem_ready_i with mem_addr_o, mem_wdata_o, mem_be_o; done_o and err_o pulses.
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic [1:0]        size_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  output logic              done_o,
  output logic              err_o
);

  state_e state_q, state_d;

  logic [3:0]  st_be_lo, st_be_hi;
  logic [63:0] st_wdata;
  logic        st_split, st_illegal;

  logic              accept, hs, bad;
  logic [ADDR_W-1:0] base_addr;

  // Second-beat payload parked here while beat 0 is on the bus.
  logic [ADDR_W-1:0] hi_addr_q;
  logic [31:0]       hi_wdata_q;
  logic [3:0]        hi_be_q;
  logic              split_q;

  store_lane_steer u_steer (
    .size    (size_i),
    .offset  (addr_i[1:0]),
    .data    (data_i),
    .be_lo   (st_be_lo),
    .be_hi   (st_be_hi),
    .wdata   (st_wdata),
    .split   (st_split),
    .illegal (st_illegal)
  );

  assign accept    = req_valid_i && req_ready_o;
  assign hs        = mem_valid_o && mem_ready_i;
  assign bad       = st_illegal || (st_split && !ALLOW_MISALIGN);
  assign base_addr = {addr_i[ADDR_W-1:2], 2'b00};

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. Rejected requests never leave IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && !bad) state_d = ST_BEAT0;
      ST_BEAT0: if (hs) state_d = split_q ? ST_BEAT1 : ST_IDLE;
      ST_BEAT1: if (hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode. done/err cycles are spent in IDLE, so a new request can land on them.
  always_comb begin
    req_ready_o = (state_q == ST_IDLE);
  end

  // Registered beat datapath and status pulses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_valid_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 32'h0;
      mem_be_o    <= 4'b0000;
      hi_addr_q   <= '0;
      hi_wdata_q  <= 32'h0;
      hi_be_q     <= 4'b0000;
      split_q     <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (bad) begin
              err_o <= 1'b1;
            end else begin
              mem_valid_o <= 1'b1;
              mem_addr_o  <= base_addr;
              mem_wdata_o <= st_wdata[31:0];
              mem_be_o    <= st_be_lo;
              // Adding at full ADDR_W width wraps the top word back to address 0.
              hi_addr_q   <= base_addr + ADDR_W'(4);
              hi_wdata_q  <= st_wdata[63:32];
              hi_be_q     <= st_be_hi;
              split_q     <= st_split;
            end
          end
        end
        ST_BEAT0: begin
          if (hs) begin
            if (split_q) begin
              // Valid stays high; second beat replaces the first on the same edge.
              mem_addr_o  <= hi_addr_q;
              mem_wdata_o <= hi_wdata_q;
              mem_be_o    <= hi_be_q;
            end else begin
              mem_valid_o <= 1'b0;
              mem_addr_o  <= '0;
              mem_wdata_o <= 32'h0;
              mem_be_o    <= 4'b0000;
              done_o      <= 1'b1;
            end
          end
        end
        ST_BEAT1: begin
          if (hs) begin
            mem_valid_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= 32'h0;
            mem_be_o    <= 4'b0000;
            done_o      <= 1'b1;
          end
        end
        default: begin
          mem_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
module tb_store_align_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance with misaligned support.
  logic        req_valid, req_ready, mem_valid, mem_ready, done, err;
  logic [31:0] addr, data, mem_addr, mem_wdata;
  logic [1:0]  size;
  logic [3:0]  mem_be;

  // Instance that rejects misaligned stores.
  logic        req_valid_b, req_ready_b, mem_valid_b, mem_ready_b, done_b, err_b;
  logic [31:0] addr_b, data_b, mem_addr_b, mem_wdata_b;
  logic [1:0]  size_b;
  logic [3:0]  mem_be_b;

  int passed = 0;
  int total  = 0;

  store_align_unit #(.ADDR_W(32), .ALLOW_MISALIGN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .addr_i(addr), .data_i(data), .size_i(size),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .done_o(done), .err_o(err)
  );

  store_align_unit #(.ADDR_W(32), .ALLOW_MISALIGN(1'b0)) dut_nm (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid_b), .req_ready_o(req_ready_b),
    .addr_i(addr_b), .data_i(data_b), .size_i(size_b),
    .mem_valid_o(mem_valid_b), .mem_ready_i(mem_ready_b),
    .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b), .mem_be_o(mem_be_b),
    .done_o(done_b), .err_o(err_b)
  );

  // Present one request for exactly one accepting edge; returns 1ns after that edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    @(posedge clk); #1;
    req_valid = 1'b1; addr = a; data = d; size = s;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %b want 1", req_ready); else passed++;
    total++; if (mem_valid !== 1'b0) $display("FAIL rst_mem_valid got %b want 0", mem_valid); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr got %h want 0", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); else passed++;
    total++; if (mem_be !== 4'b0000) $display("FAIL rst_mem_be got %b want 0000", mem_be); else passed++;
    total++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL rst_done_err got %b%b want 00", done, err); else passed++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_byte();
    mem_ready = 1'b1;
    issue(32'h0000_1002, 32'hAABB_CCDD, 2'b00);
    @(negedge clk);
    total++; if (mem_valid !== 1'b1) $display("FAIL byte_valid got %b want 1", mem_valid); else passed++;
    total++; if (mem_addr !== 32'h0000_1000) $display("FAIL byte_addr got %h want 00001000", mem_addr); else passed++;
    total++; if (mem_be !== 4'b0100) $display("FAIL byte_be got %b want 0100", mem_be); else passed++;
    total++; if (mem_wdata !== 32'h00DD_0000) $display("FAIL byte_wdata got %h want 00dd0000", mem_wdata); else passed++;
    total++; if (req_ready !== 1'b0) $display("FAIL byte_busy_ready got %b want 0", req_ready); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL byte_done got %b want 1", done); else passed++;
    total++; if (mem_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL byte_idle got valid=%b ready=%b want 0/1", mem_valid, req_ready); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL byte_done_pulse got %b want 0", done); else passed++;
  endtask

  task automatic test_backpressure();
    mem_ready = 1'b0;
    issue(32'h0000_2000, 32'h1122_3344, 2'b10);
    repeat (3) begin
      @(negedge clk);
      total++; if (mem_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", mem_valid); else passed++;
      total++; if (mem_addr !== 32'h0000_2000) $display("FAIL bp_addr got %h want 00002000", mem_addr); else passed++;
      total++; if (mem_be !== 4'b1111) $display("FAIL bp_be got %b want 1111", mem_be); else passed++;
      total++; if (mem_wdata !== 32'h1122_3344) $display("FAIL bp_wdata got %h want 11223344", mem_wdata); else passed++;
      total++; if (done !== 1'b0) $display("FAIL bp_early_done got %b want 0", done); else passed++;
      @(posedge clk);
    end
    #1 mem_ready = 1'b1;
    @(negedge clk);
    total++; if (mem_valid !== 1'b1) $display("FAIL bp_valid_last got %b want 1", mem_valid); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b1 || mem_valid !== 1'b0) $display("FAIL bp_done got done=%b valid=%b want 1/0", done, mem_valid); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL bp_done_pulse got %b want 0", done); else passed++;
  endtask

  task automatic test_misaligned_word();
    mem_ready = 1'b1;
    issue(32'h0000_3001, 32'h1122_3344, 2'b10);
    @(negedge clk);
    total++; if (mem_addr !== 32'h0000_3000) $display("FAIL mw_b0_addr got %h want 00003000", mem_addr); else passed++;
    total++; if (mem_be !== 4'b1110) $display("FAIL mw_b0_be got %b want 1110", mem_be); else passed++;
    total++; if (mem_wdata !== 32'h2233_4400) $display("FAIL mw_b0_wdata got %h want 22334400", mem_wdata); else passed++;
    @(negedge clk);
    total++; if (mem_valid !== 1'b1 || done !== 1'b0) $display("FAIL mw_b1_valid got valid=%b done=%b want 1/0", mem_valid, done); else passed++;
    total++; if (mem_addr !== 32'h0000_3004) $display("FAIL mw_b1_addr got %h want 00003004", mem_addr); else passed++;
    total++; if (mem_be !== 4'b0001) $display("FAIL mw_b1_be got %b want 0001", mem_be); else passed++;
    total++; if (mem_wdata !== 32'h0000_0011) $display("FAIL mw_b1_wdata got %h want 00000011", mem_wdata); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b1 || mem_valid !== 1'b0) $display("FAIL mw_done got done=%b valid=%b want 1/0", done, mem_valid); else passed++;
  endtask

  task automatic test_half_wrap();
    mem_ready = 1'b1;
    issue(32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01);
    @(negedge clk);
    total++; if (mem_addr !== 32'hFFFF_FFFC) $display("FAIL hw_b0_addr got %h want fffffffc", mem_addr); else passed++;
    total++; if (mem_be !== 4'b1000) $display("FAIL hw_b0_be got %b want 1000", mem_be); else passed++;
    total++; if (mem_wdata !== 32'hEF00_0000) $display("FAIL hw_b0_wdata got %h want ef000000", mem_wdata); else passed++;
    @(negedge clk);
    total++; if (mem_addr !== 32'h0000_0000) $display("FAIL hw_b1_addr got %h want 00000000", mem_addr); else passed++;
    total++; if (mem_be !== 4'b0001) $display("FAIL hw_b1_be got %b want 0001", mem_be); else passed++;
    total++; if (mem_wdata !== 32'h0000_00BE) $display("FAIL hw_b1_wdata got %h want 000000be", mem_wdata); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL hw_done got %b want 1", done); else passed++;
  endtask

  task automatic test_err_back_to_back();
    mem_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; addr = 32'h0000_0010; data = 32'hDEAD_BEEF; size = 2'b11;
    @(posedge clk); #1;
    // Next request is already waiting while err_o pulses.
    addr = 32'h0000_4003; data = 32'h0000_005A; size = 2'b00;
    @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL err_pulse got %b want 1", err); else passed++;
    total++; if (mem_valid !== 1'b0) $display("FAIL err_no_beat got %b want 0", mem_valid); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL err_ready got %b want 1", req_ready); else passed++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (err !== 1'b0) $display("FAIL err_pulse_end got %b want 0", err); else passed++;
    total++; if (mem_valid !== 1'b1) $display("FAIL b2b_valid got %b want 1", mem_valid); else passed++;
    total++; if (mem_addr !== 32'h0000_4000) $display("FAIL b2b_addr got %h want 00004000", mem_addr); else passed++;
    total++; if (mem_be !== 4'b1000) $display("FAIL b2b_be got %b want 1000", mem_be); else passed++;
    total++; if (mem_wdata !== 32'h5A00_0000) $display("FAIL b2b_wdata got %h want 5a000000", mem_wdata); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL b2b_done got %b want 1", done); else passed++;
  endtask

  task automatic test_no_misalign();
    mem_ready_b = 1'b1;
    @(posedge clk); #1;
    req_valid_b = 1'b1; addr_b = 32'h0000_0002; data_b = 32'h1234_5678; size_b = 2'b10;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    @(negedge clk);
    total++; if (err_b !== 1'b1) $display("FAIL nm_err got %b want 1", err_b); else passed++;
    total++; if (mem_valid_b !== 1'b0) $display("FAIL nm_no_beat got %b want 0", mem_valid_b); else passed++;
    total++; if (req_ready_b !== 1'b1) $display("FAIL nm_ready got %b want 1", req_ready_b); else passed++;
    @(negedge clk);
    total++; if (err_b !== 1'b0 || mem_valid_b !== 1'b0) $display("FAIL nm_after got err=%b valid=%b want 0/0", err_b, mem_valid_b); else passed++;
    // An aligned word is still issued normally.
    @(posedge clk); #1;
    req_valid_b = 1'b1; addr_b = 32'h0000_0008; data_b = 32'hCAFE_F00D; size_b = 2'b10;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    @(negedge clk);
    total++; if (mem_valid_b !== 1'b1 || err_b !== 1'b0) $display("FAIL nm_aligned got valid=%b err=%b want 1/0", mem_valid_b, err_b); else passed++;
    total++; if (mem_wdata_b !== 32'hCAFE_F00D || mem_be_b !== 4'b1111) $display("FAIL nm_aligned_data got %h/%b want cafef00d/1111", mem_wdata_b, mem_be_b); else passed++;
    @(negedge clk);
    total++; if (done_b !== 1'b1) $display("FAIL nm_done got %b want 1", done_b); else passed++;
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b1;
    issue(32'h0000_3001, 32'h1122_3344, 2'b10);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    total++; if (mem_valid !== 1'b1 || mem_be !== 4'b0001) $display("FAIL rm_beat1 got valid=%b be=%b want 1/0001", mem_valid, mem_be); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (mem_valid !== 1'b0) $display("FAIL rm_valid got %b want 0", mem_valid); else passed++;
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'b0000) $display("FAIL rm_bus got %h/%h/%b want zeros", mem_addr, mem_wdata, mem_be); else passed++;
    total++; if (req_ready !== 1'b1 || done !== 1'b0) $display("FAIL rm_ready_done got %b/%b want 1/0", req_ready, done); else passed++;
    @(negedge clk); rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++; if (done !== 1'b0 || mem_valid !== 1'b0) $display("FAIL rm_quiet got done=%b valid=%b want 0/0", done, mem_valid); else passed++;
    end
    issue(32'h0000_5001, 32'h0000_0077, 2'b00);
    @(negedge clk);
    total++; if (mem_be !== 4'b0010 || mem_wdata !== 32'h0000_7700) $display("FAIL rm_next got %b/%h want 0010/00007700", mem_be, mem_wdata); else passed++;
    total++; if (mem_addr !== 32'h0000_5000) $display("FAIL rm_next_addr got %h want 00005000", mem_addr); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL rm_next_done got %b want 1", done); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = 1'b0; addr = 32'h0; data = 32'h0; size = 2'b00; mem_ready = 1'b0;
    req_valid_b = 1'b0; addr_b = 32'h0; data_b = 32'h0; size_b = 2'b00; mem_ready_b = 1'b0;
    test_reset();
    test_byte();
    test_backpressure();
    test_misaligned_word();
    test_half_wrap();
    test_err_back_to_back();
    test_no_misalign();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
